// File: rtl/system_sysid_ext.sv
// System-ID and uptime peripheral: an Avalon-MM slave with read latency 1. It serves build
// ID, timestamp, capabilities, a free-running uptime counter with coherent 64-bit reads, and scratch registers.
module system_sysid_ext #(
   parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP   = 32'd1394144997,
   parameter int unsigned NUM_SCRATCH = 4,
   parameter int unsigned CNT_WIDTH   = 48
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   localparam int unsigned SnapWidth = CNT_WIDTH - 32;

   localparam logic [31:0] CapsValue = {16'h0002, 1'b0, 7'(CNT_WIDTH), 4'h0, 4'(NUM_SCRATCH)};

   localparam logic [3:0] AddrId      = 4'd0;
   localparam logic [3:0] AddrStamp   = 4'd1;
   localparam logic [3:0] AddrCaps    = 4'd2;
   localparam logic [3:0] AddrCtrl    = 4'd3;
   localparam logic [3:0] AddrUpLo    = 4'd4;
   localparam logic [3:0] AddrUpHi    = 4'd5;
   localparam int unsigned ScratchBase = 8;

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [SnapWidth-1:0] snap_q, snap_d;
   logic                 enable_q, enable_d;
   logic [31:0]          scratch_q [NUM_SCRATCH];
   logic [31:0]          scratch_d [NUM_SCRATCH];
   logic [31:0]          readdata_q, readdata_d;
   logic                 rvalid_q;
   logic [31:0]          rmux;

   logic ctrl_wr;
   logic clear;
   logic lo_rd;

   assign ctrl_wr = write && (address == AddrCtrl) && byteenable[0];
   assign clear   = ctrl_wr && writedata[1];
   assign lo_rd   = read && (address == AddrUpLo);

   // Read mux sees only pre-write register values, so a same-cycle write never leaks into the read.
   always_comb begin
      rmux = '0;
      case (address)
         AddrId:    rmux = ID_VALUE;
         AddrStamp: rmux = TIMESTAMP;
         AddrCaps:  rmux = CapsValue;
         AddrCtrl:  rmux = {31'b0, enable_q};
         AddrUpLo:  rmux = cnt_q[31:0];
         AddrUpHi:  rmux = 32'(snap_q);
         default:   rmux = '0;
      endcase
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         if (address == 4'(ScratchBase + i)) begin
            rmux = scratch_q[i];
         end
      end
   end

   always_comb begin
      readdata_d = readdata_q;
      if (read) begin
         readdata_d = rmux;
      end
   end

   // Clear wins over increment; the counter wraps silently at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable_q) begin
         cnt_d = cnt_q + CntOne;
      end
   end

   // The high half is latched from the same counter value the LO read returns.
   always_comb begin
      snap_d = snap_q;
      if (lo_rd) begin
         snap_d = cnt_q[CNT_WIDTH-1:32];
      end
   end

   always_comb begin
      enable_d = enable_q;
      if (ctrl_wr) begin
         enable_d = writedata[0];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         scratch_d[i] = scratch_q[i];
         for (int b = 0; b < 4; b++) begin
            if (write && (address == 4'(ScratchBase + i)) && byteenable[b]) begin
               scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q      <= '0;
         snap_q     <= '0;
         enable_q   <= 1'b1;
         readdata_q <= '0;
         rvalid_q   <= 1'b0;
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch_q[i] <= '0;
         end
      end else begin
         cnt_q      <= cnt_d;
         snap_q     <= snap_d;
         enable_q   <= enable_d;
         readdata_q <= readdata_d;
         rvalid_q   <= read;
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch_q[i] <= scratch_d[i];
         end
      end
   end

   assign readdata = readdata_q;
   // A read accepted just before reset must not surface during the reset cycle.
   assign readdatavalid = rvalid_q & ~reset;

endmodule

// File: tb/tb_system_sysid_ext.sv
// Scoreboard bench for system_sysid_ext: a cycle-level reference model queues expected read
// results, and a monitor pops and compares them whenever readdatavalid is seen.
module tb_system_sysid_ext;

   localparam int unsigned NS  = 4;
   localparam int unsigned CW  = 48;
   localparam logic [31:0] IDV = 32'h0000_0000;
   localparam logic [31:0] TSV = 32'd1394144997;
   localparam bit [63:0]   Mask = (64'd1 << CW) - 64'd1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [3:0]  byteenable = '0;
   logic [31:0] readdata;
   logic        readdatavalid;

   always #5 clock = ~clock;

   system_sysid_ext #(
      .ID_VALUE    (IDV),
      .TIMESTAMP   (TSV),
      .NUM_SCRATCH (NS),
      .CNT_WIDTH   (CW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic [3:0]  addr;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: what the peripheral holds during the current cycle.
   bit [63:0] mcnt;
   bit [31:0] msnap;
   bit        men;
   bit [31:0] mscr [NS];
   logic [CW-1:0] dep_val;

   function automatic bit [31:0] model_read(input bit [3:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0) return IDV;
      if (ai == 1) return TSV;
      if (ai == 2) return 32'h0002_0000 | ((CW & 32'h7f) << 8) | (NS & 32'hf);
      if (ai == 3) return {31'b0, men};
      if (ai == 4) return mcnt[31:0];
      if (ai == 5) return msnap;
      if (ai >= 8 && ai < 8 + int'(NS)) return mscr[ai-8];
      return 32'h0;
   endfunction

   // Drives one bus cycle, queues any expected read response, then advances the model.
   task automatic step(input bit rst, input bit rd, input bit wr, input bit [3:0] a,
                       input bit [31:0] wd, input bit [3:0] be);
      int ai;
      bit clr;
      ai = int'(a);
      reset = rst; read = rd; write = wr; address = a; writedata = wd; byteenable = be;
      if (rst) begin
         if (sb.size() > 0 && sb[$].cyc == cyc) void'(sb.pop_back());
         mcnt = 0; msnap = 0; men = 1'b1;
         for (int i = 0; i < NS; i++) mscr[i] = 0;
      end else begin
         if (rd) sb.push_back('{cyc + 1, model_read(a), a});
         if (rd && ai == 4) msnap = 32'(mcnt >> 32);
         clr = wr && ai == 3 && be[0] && wd[1];
         if (clr) mcnt = 0;
         else if (men) mcnt = (mcnt + 64'd1) & Mask;
         if (wr && ai == 3 && be[0]) men = wd[0];
         if (wr && ai >= 8 && ai < 8 + int'(NS))
            for (int b = 0; b < 4; b++)
               if (be[b]) mscr[ai-8][8*b +: 8] = wd[8*b +: 8];
      end
      @(posedge clock);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 32'h0, 4'h0);
   endtask

   task automatic rd(input bit [3:0] a);
      step(0, 1, 0, a, 32'h0, 4'h0);
   endtask

   task automatic wr(input bit [3:0] a, input bit [31:0] d, input bit [3:0] be);
      step(0, 0, 1, a, d, be);
   endtask

   // Loads the uptime counter directly so carry/wrap boundaries are reachable quickly.
   task automatic deposit(input bit [63:0] v);
      dep_val = v[CW-1:0];
      force dut.cnt_q = dep_val;
      release dut.cnt_q;
      mcnt = v & Mask;
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (readdatavalid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_valid cyc=%0d actual=%08h required=no valid", cyc,
                        readdata);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (readdata !== e.data || cyc != e.cyc) begin
                  n_err++;
                  $display("FAIL read_w%0d actual=%08h@%0d required=%08h@%0d", e.addr,
                           readdata, cyc, e.data, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      @(posedge clock);
      #2;
      step(1, 0, 0, 4'd0, 32'h0, 4'h0);
      step(1, 1, 0, 4'd0, 32'h0, 4'h0);
      n_cmp++;
      if (readdata !== 32'h0 || readdatavalid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state actual=%08h/%b required=00000000/0", readdata,
                  readdatavalid);
      end

      // Identification words back-to-back, plus reserved and unmapped words.
      rd(4'd0); rd(4'd1); rd(4'd2); rd(4'd6); rd(4'd15); rd(4'd3);
      idle(2);

      // Freeze, then resume and check spacing between LO reads.
      idle(5);
      wr(4'd3, 32'h0, 4'h1);
      idle(10);
      rd(4'd4); rd(4'd3);
      wr(4'd3, 32'h1, 4'h1);
      rd(4'd4); idle(3); rd(4'd4); rd(4'd4);
      // CONTROL write without byte lane 0 is ignored.
      wr(4'd3, 32'h0, 4'he);
      rd(4'd3); rd(4'd4);

      // 32-bit carry: LO then HI before and after the carry.
      deposit(64'h0000_0000_FFFF_FFFE);
      rd(4'd4); rd(4'd5); rd(4'd4); rd(4'd5); idle(2); rd(4'd4); rd(4'd5);
      // Full wrap of the counter.
      deposit(64'h0000_FFFF_FFFF_FFFE);
      rd(4'd4); rd(4'd5); idle(1); rd(4'd4); rd(4'd5);
      // HI without a fresh LO returns the stale snapshot.
      idle(4); rd(4'd5);

      // Clear with simultaneous LO read at count 500.
      wr(4'd3, 32'h3, 4'h1);
      idle(500);
      step(0, 1, 1, 4'd4, 32'h3, 4'h1);
      rd(4'd4); rd(4'd5); rd(4'd3);

      // Scratch byte lanes, and the unmapped word just past the bank.
      wr(4'd9, 32'hDEAD_BEEF, 4'hF);
      wr(4'd9, 32'h1122_3344, 4'b0101);
      rd(4'd9);
      wr(4'd12, 32'hCAFE_F00D, 4'hF);
      rd(4'd12);
      wr(4'd8, 32'hA5A5_A5A5, 4'h0);
      rd(4'd8);
      // Same-cycle read and write returns the pre-write value.
      step(0, 1, 1, 4'd9, 32'h5555_6666, 4'hF);
      rd(4'd9);

      // Read followed by reset: the result is dropped, state reinitialises.
      wr(4'd3, 32'h0, 4'h1);
      rd(4'd0);
      step(1, 0, 0, 4'd0, 32'h0, 4'h0);
      rd(4'd3); rd(4'd9); rd(4'd4); rd(4'd5);

      // Randomised traffic, with occasional resets.
      for (int i = 0; i < 600; i++) begin
         bit r, w, rs;
         bit [3:0] a;
         bit [31:0] d;
         rs = ($urandom_range(0, 99) == 0);
         r  = $urandom_range(0, 1) == 1;
         w  = $urandom_range(0, 2) == 0;
         a  = 4'($urandom_range(0, 15));
         d  = $urandom;
         if (a == 4'd3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         step(rs, r, w, a, d, 4'($urandom_range(0, 15)));
      end

      idle(3);
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL pending_reads actual=%0d outstanding required=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
